// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and default sizing.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefLat   = 4;

endpackage

// File: rtl/dmem_responder_array.sv
// Word storage: synchronous write, asynchronous read, contents survive reset.
module dmem_responder_array #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port, no reset on purpose so stored data survives rst.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory target: captures one request, stalls the pipeline for LAT cycles,
// then completes with a one-cycle done pulse.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned LAT    = DefLat
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       addr,
  input  logic              re,
  input  logic              we,
  input  logic [DATA_W-1:0] wrt_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall,
  output logic              done,
  output logic              err
);

  // Counter holds LAT-2 at most; BUSY spans LAT-1 cycles.
  localparam int unsigned CntW = (LAT > 2) ? $clog2(LAT - 1) : 1;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [15:0]       addr_q;
  logic [DATA_W-1:0] data_q;
  logic              re_q, we_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              done_q, err_q;

  logic              req, start, enter_done, mismatch, mem_we;
  logic [15:0]       acc_addr;
  logic [DATA_W-1:0] acc_data, mem_rdata;
  logic              acc_re, acc_we;

  assign req   = re | we;
  assign start = (state_q == StIdle) && req;

  // Select the request that completes on the coming edge: live inputs when LAT==1 skips BUSY.
  always_comb begin
    acc_addr   = addr_q;
    acc_data   = data_q;
    acc_re     = re_q;
    acc_we     = we_q;
    enter_done = 1'b0;
    if (state_q == StIdle) begin
      acc_addr   = addr;
      acc_data   = wrt_data;
      acc_re     = re;
      acc_we     = we;
      enter_done = req && (LAT == 1);
    end else if (state_q == StBusy) begin
      enter_done = (cnt_q == '0);
    end
  end

  assign mismatch = (addr != addr_q) || (wrt_data != data_q) || (re != re_q) || (we != we_q);
  // Gating with rst keeps an aborted store out of storage when reset coincides with the edge.
  assign mem_we   = enter_done && acc_we && !rst;

  dmem_responder_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (acc_addr[ADDR_W-1:0]),
    .wdata(acc_data),
    .rdata(mem_rdata)
  );

  // FSM, latency counter, request capture, completion data and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= enter_done;
      // Write-through: a combined re&we returns the data being written.
      if (enter_done && acc_re) rd_data_q <= acc_we ? acc_data : mem_rdata;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            addr_q <= addr;
            data_q <= wrt_data;
            re_q   <= re;
            we_q   <= we;
            if (LAT == 1) begin
              state_q <= StDone;
            end else begin
              cnt_q   <= CntW'(LAT - 2);
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          if (mismatch) err_q <= 1'b1;
          if (cnt_q == '0) state_q <= StDone;
          else             cnt_q   <= cnt_q - CntW'(1);
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall   = !rst && ((state_q == StBusy) || start);
  assign done    = done_q;
  assign rd_data = rd_data_q;
  assign err     = err_q;

endmodule
